// File: rtl/rv32_pipe_pkg.sv
// Shared types and constants for the RV32I 5-stage pipeline control blocks.
package rv32_pipe_pkg;

  localparam int             REG_IDX_W = 5;
  localparam logic [4:0]     REG_ZERO  = 5'd0;

  // Stall/flush controller states: normal flow or frozen on a data-memory wait.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_e;

  // True when an operand that is actually read names the given destination register.
  function automatic logic reg_match(input logic                 use_reg,
                                     input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dst);
    return use_reg && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: ID/EX operand info and memory
// handshake flow in, register enables/flushes flow back out to the datapath.
interface pipeline_hazard_ctrl_if;
  import rv32_pipe_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic                 ex_valid;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_mem_read;
  logic                 ex_redirect;
  logic                 mem_req;
  logic                 mem_ready;

  logic                 pc_en;
  logic                 ifid_en;
  logic                 ifid_flush;
  logic                 idex_en;
  logic                 idex_flush;
  logic                 exmem_en;
  logic                 exmem_flush;

  // Datapath side: reports stage contents, obeys enables/flushes.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_valid, ex_rd, ex_mem_read, ex_redirect,
    output mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_rd, ex_mem_read, ex_redirect,
    input  mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the EX instruction is a load whose destination is
// read by the instruction in ID. Pure combinational so the forwarding unit can
// reuse it unchanged.
module hazard_detect
  import rv32_pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_valid,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  output logic                 load_use
);

  // x0 is hard-wired zero, so a load targeting it never produces a dependency.
  always_comb begin
    load_use = ex_valid && ex_mem_read && (ex_rd != REG_ZERO) &&
               (reg_match(id_use_rs1, id_rs1, ex_rd) ||
                reg_match(id_use_rs2, id_rs2, ex_rd));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline: load-use
// bubbles, wrong-path squash on redirect, whole-pipe freeze on memory wait,
// saturating stall counter and sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  pipeline_hazard_ctrl_if.slave    bus,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic                     mem_err
);

  localparam int  WAIT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit  TIMEOUT_EN = (MEM_TIMEOUT != 0);

  hazard_state_e       state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
  logic                mem_err_q, mem_err_d;

  logic load_use;
  logic mem_stall;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;

  hazard_detect u_hazard_detect (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .ex_valid    (bus.ex_valid),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_stall = bus.mem_req && !bus.mem_ready;

  // Enable/flush mux. Staying in MEM_WAIT happens exactly when mem_stall holds
  // (ready or a dropped request both leave), so the freeze condition is the
  // same in both states and the exit cycle falls straight through to the
  // redirect/load-use rules with no dead cycle.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (bus.ex_redirect) begin
      // Both younger instructions are on the wrong path; any load-use on the
      // ID instruction is moot because it is being killed.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push one bubble into EX.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Next-state for FSM, wait counter, stall counter and sticky error.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    stall_cycles_d = stall_cycles_q;
    mem_err_d      = mem_err_q;
    if (rst) begin
      state_d        = RUN;
      wait_cnt_d     = '0;
      stall_cycles_d = '0;
      mem_err_d      = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_stall) begin
            if (wait_cnt_q != {WAIT_W{1'b1}}) begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end else begin
            state_d    = RUN;
            wait_cnt_d = '0;
          end
        end
        default: begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      endcase
      // wait_cnt_d is the number of frozen cycles including this one.
      if (TIMEOUT_EN && mem_stall && (wait_cnt_d == WAIT_W'(MEM_TIMEOUT))) begin
        mem_err_d = 1'b1;
      end
      if (!pc_en && !(&stall_cycles_q)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    state_q        <= state_d;
    wait_cnt_q     <= wait_cnt_d;
    stall_cycles_q <= stall_cycles_d;
    mem_err_q      <= mem_err_d;
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_en    = exmem_en;
  assign bus.exmem_flush = exmem_flush;
  assign stall_cycles    = stall_cycles_q;
  assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// constant expectations, then a randomized run against a behavioural model.
// Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush}
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 8;

  localparam logic [6:0] C_RESET = 7'b0010101;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_REDIR = 7'b1111110;
  localparam logic [6:0] C_LOADU = 7'b0001110;
  localparam logic [6:0] C_RUN   = 7'b1101010;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_run;     // consecutive frozen cycles completed
  int m_stall;   // expected stall_cycles
  bit m_err;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (hif),
    .stall_cycles (stall_cycles),
    .mem_err      (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en,
            hif.idex_flush, hif.exmem_en, hif.exmem_flush};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0;
    hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
    hif.ex_valid = 1'b0; hif.ex_rd = 5'd0;
    hif.ex_mem_read = 1'b0; hif.ex_redirect = 1'b0;
    hif.mem_req = 1'b0; hif.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Expected controls from the priority rules applied to the current inputs.
  function automatic logic [6:0] model_ctrl();
    bit hz;
    hz = hif.ex_valid && hif.ex_mem_read && (hif.ex_rd != 0) &&
         ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) ||
          (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
    if (rst)                               return C_RESET;
    if (hif.mem_req && !hif.mem_ready)     return C_FREEZE;
    if (hif.ex_redirect)                   return C_REDIR;
    if (hz)                                return C_LOADU;
    return C_RUN;
  endfunction

  // Advance the model across one clock edge.
  task automatic model_tick(input logic [6:0] ctrl);
    if (rst) begin
      m_run = 0; m_stall = 0; m_err = 1'b0;
    end else begin
      if (!ctrl[6] && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (hif.mem_req && !hif.mem_ready) begin
        m_run++;
        if (MEM_TIMEOUT != 0 && m_run >= MEM_TIMEOUT) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs() !== C_RESET) begin
      errors++; $display("FAIL reset_ctrl: got %b want %b", obs(), C_RESET);
    end
    checks++;
    if (stall_cycles !== 3'd0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_regs: stall=%0d err=%b want 0/0", stall_cycles, mem_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs() !== C_RUN) begin
      errors++; $display("FAIL reset_release: got %b want %b", obs(), C_RUN);
    end
    tick();
    checks++;
    if (stall_cycles !== 3'd0) begin
      errors++; $display("FAIL reset_cnt_after: got %0d want 0", stall_cycles);
    end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    hif.ex_valid = 1'b1; hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5;
    hif.id_rs1 = 5'd5; hif.id_use_rs1 = 1'b1;
    #1;
    checks++;
    if (obs() !== C_LOADU) begin
      errors++; $display("FAIL load_use_rs1: got %b want %b", obs(), C_LOADU);
    end
    tick();
    hif.ex_valid = 1'b0;  // bubble now in EX
    #1;
    checks++;
    if (obs() !== C_RUN || stall_cycles !== 3'd1) begin
      errors++; $display("FAIL load_use_one_bubble: got %b cnt=%0d want %b cnt=1", obs(), stall_cycles, C_RUN);
    end
    hif.ex_valid = 1'b1; hif.ex_rd = 5'd0; hif.id_rs1 = 5'd0;
    #1;
    checks++;
    if (obs() !== C_RUN) begin
      errors++; $display("FAIL load_use_x0: got %b want %b", obs(), C_RUN);
    end
    tick();
    hif.ex_rd = 5'd7; hif.id_rs1 = 5'd3; hif.id_rs2 = 5'd7;
    hif.id_use_rs1 = 1'b1; hif.id_use_rs2 = 1'b1;
    #1;
    checks++;
    if (obs() !== C_LOADU) begin
      errors++; $display("FAIL load_use_rs2: got %b want %b", obs(), C_LOADU);
    end
    tick();
    hif.id_use_rs2 = 1'b0;
    #1;
    checks++;
    if (obs() !== C_RUN || stall_cycles !== 3'd2) begin
      errors++; $display("FAIL load_use_unused_rs2: got %b cnt=%0d want %b cnt=2", obs(), stall_cycles, C_RUN);
    end
    hif.id_use_rs2 = 1'b1; hif.ex_mem_read = 1'b0;
    #1;
    checks++;
    if (obs() !== C_RUN) begin
      errors++; $display("FAIL load_use_not_load: got %b want %b", obs(), C_RUN);
    end
    $display("test_load_use done");
  endtask

  task automatic test_redirect();
    do_reset();
    hif.ex_valid = 1'b1; hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd9;
    hif.id_rs1 = 5'd9; hif.id_use_rs1 = 1'b1; hif.ex_redirect = 1'b1;
    #1;
    checks++;
    if (obs() !== C_REDIR) begin
      errors++; $display("FAIL redirect_over_load_use: got %b want %b", obs(), C_REDIR);
    end
    tick();
    checks++;
    if (stall_cycles !== 3'd0) begin
      errors++; $display("FAIL redirect_no_stall: got %0d want 0", stall_cycles);
    end
    $display("test_redirect done");
  endtask

  task automatic test_mem_wait();
    do_reset();
    hif.mem_req = 1'b1; hif.mem_ready = 1'b0; hif.ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs() !== C_FREEZE) begin
        errors++; $display("FAIL mem_wait_freeze[%0d]: got %b want %b", i, obs(), C_FREEZE);
      end
      tick();
    end
    hif.mem_ready = 1'b1;
    #1;
    checks++;
    if (obs() !== C_REDIR || stall_cycles !== 3'd4) begin
      errors++; $display("FAIL mem_wait_exit: got %b cnt=%0d want %b cnt=4", obs(), stall_cycles, C_REDIR);
    end
    tick();
    hif.ex_redirect = 1'b0; hif.mem_ready = 1'b0;
    tick();  // one more frozen cycle, then drop the request
    hif.mem_req = 1'b0;
    #1;
    checks++;
    if (obs() !== C_RUN || stall_cycles !== 3'd5) begin
      errors++; $display("FAIL mem_req_drop: got %b cnt=%0d want %b cnt=5", obs(), stall_cycles, C_RUN);
    end
    $display("test_mem_wait done");
  endtask

  task automatic test_timeout();
    do_reset();
    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if (mem_err !== (i >= MEM_TIMEOUT)) begin
        errors++; $display("FAIL timeout_err[%0d]: got %b want %b", i, mem_err, (i >= MEM_TIMEOUT));
      end
    end
    hif.mem_ready = 1'b1;
    tick();
    hif.mem_req = 1'b0;
    tick();
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b want 1", mem_err);
    end
    $display("test_timeout done");
  endtask

  task automatic test_saturation();
    do_reset();
    hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (stall_cycles !== 3'((i > 7) ? 7 : i)) begin
        errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, stall_cycles, (i > 7) ? 7 : i);
      end
    end
    rst = 1'b1;  // still waiting on memory
    #1;
    checks++;
    if (obs() !== C_RESET) begin
      errors++; $display("FAIL rst_mid_wait_ctrl: got %b want %b", obs(), C_RESET);
    end
    tick();
    rst = 1'b0; hif.mem_req = 1'b0;
    #1;
    checks++;
    if (obs() !== C_RUN || stall_cycles !== 3'd0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wait_after: got %b cnt=%0d err=%b want %b 0 0", obs(), stall_cycles, mem_err, C_RUN);
    end
    // A fresh wait must count from zero again: no error before the full timeout.
    hif.mem_req = 1'b1;
    repeat (MEM_TIMEOUT - 1) tick();
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wait_recount: got %b want 0", mem_err);
    end
    hif.mem_req = 1'b0;
    $display("test_saturation done");
  endtask

  task automatic test_random();
    logic [6:0] exp;
    do_reset();
    m_run = 0; m_stall = 0; m_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 99) < 2);
      hif.id_rs1      = 5'($urandom_range(0, 3));
      hif.id_rs2      = 5'($urandom_range(0, 3));
      hif.id_use_rs1  = 1'($urandom_range(0, 1));
      hif.id_use_rs2  = 1'($urandom_range(0, 1));
      hif.ex_valid    = ($urandom_range(0, 9) < 8);
      hif.ex_rd       = 5'($urandom_range(0, 3));
      hif.ex_mem_read = 1'($urandom_range(0, 1));
      hif.ex_redirect = ($urandom_range(0, 99) < 15);
      hif.mem_req     = ($urandom_range(0, 99) < 40);
      hif.mem_ready   = ($urandom_range(0, 99) < 30);
      #1;
      exp = model_ctrl();
      checks++;
      if (obs() !== exp || stall_cycles !== 3'(m_stall) || mem_err !== m_err) begin
        errors++;
        $display("FAIL random[%0d]: ctrl=%b cnt=%0d err=%b want ctrl=%b cnt=%0d err=%b",
                 n, obs(), stall_cycles, mem_err, exp, m_stall, m_err);
      end
      model_tick(exp);
      tick();
    end
    rst = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
